// File: rtl/ras_stack_ckpt.sv
// ras_stack_ckpt: circular return-address stack with single-entry checkpoint/restore
module ras_stack_ckpt #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    input  logic             checkpoint,
    input  logic             restore,
    output logic [WIDTH-1:0] top,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    tos;
    logic [AW-1:0]    snap_tos;
    logic [AW:0]      snap_count;
    logic [WIDTH-1:0] snap_val;
    logic             snap_valid;
    logic             do_restore, active, do_push, do_pop, do_repl;

    assign empty      = count == '0;
    assign full       = count == FULL_CNT;
    assign top        = empty ? '0 : mem[tos];
    // a restore without a saved snapshot is a no-op and lets the other requests through
    assign do_restore = restore && snap_valid;
    assign active     = !stall && !do_restore;
    assign do_repl    = push && pop && !empty;
    assign do_push    = push && (!pop || empty);
    assign do_pop     = pop && !push && !empty;

    // stack state, snapshot and overflow pulse; restore beats stall, stall beats push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            tos        <= '0;
            count      <= '0;
            snap_tos   <= '0;
            snap_count <= '0;
            snap_val   <= '0;
            snap_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= active && do_push && full;
            if (do_restore) begin
                tos           <= snap_tos;
                count         <= snap_count;
                mem[snap_tos] <= snap_val;
            end else if (active) begin
                if (checkpoint) begin
                    snap_tos   <= tos;
                    snap_count <= count;
                    snap_val   <= mem[tos];
                    snap_valid <= 1'b1;
                end
                if (do_repl) begin
                    mem[tos] <= data;
                end else if (do_push) begin
                    tos              <= tos + 1'b1;
                    mem[tos + 1'b1]  <= data;
                    if (!full) count <= count + 1'b1;
                end else if (do_pop) begin
                    tos   <= tos - 1'b1;
                    count <= count - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ras_stack_ckpt.sv
// tb_ras_stack_ckpt: scoreboard bench with a behavioural stack model and random stimulus
module tb_ras_stack_ckpt;
    localparam int D = 8;

    logic        clk = 0;
    logic        reset = 0;
    logic        stall = 0, push = 0, pop = 0, checkpoint = 0, restore = 0;
    logic [31:0] data = 0;
    logic [31:0] top;
    logic [3:0]  count;
    logic        empty, full, overflow;

    ras_stack_ckpt #(.DEPTH(8), .AW(3), .WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .push(push), .pop(pop),
        .data(data), .checkpoint(checkpoint), .restore(restore),
        .top(top), .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] top;
        int          cnt;
        logic        ov;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;

    // reference model: slots indexed modulo D, stack height tracked as a plain int
    logic [31:0] m_mem [D];
    int          m_tos, m_cnt, s_tos, s_cnt;
    logic [31:0] s_val;
    bit          s_ok, m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("top", top, e.top);
        chk("count", 32'(count), 32'(e.cnt));
        chk("empty", 32'(empty), 32'(e.cnt == 0));
        chk("full", 32'(full), 32'(e.cnt == D));
        chk("overflow", 32'(overflow), 32'(e.ov));
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.top = (m_cnt != 0) ? m_mem[m_tos] : 32'h0;
        e.cnt = m_cnt;
        e.ov  = m_ov;
        return e;
    endfunction

    function automatic void model_reset();
        foreach (m_mem[i]) m_mem[i] = 0;
        m_tos = 0; m_cnt = 0; s_tos = 0; s_cnt = 0; s_val = 0; s_ok = 0; m_ov = 0;
    endfunction

    function automatic void model_step(bit p, bit po, logic [31:0] d, bit ck, bit rs, bit st);
        m_ov = 0;
        if (rs && s_ok) begin
            m_tos = s_tos; m_cnt = s_cnt; m_mem[s_tos] = s_val;
        end else if (!st) begin
            if (ck) begin
                s_tos = m_tos; s_cnt = m_cnt; s_val = m_mem[m_tos]; s_ok = 1;
            end
            if (p && po && m_cnt > 0) m_mem[m_tos] = d;
            else if (p) begin
                m_tos = (m_tos + 1) % D;
                m_mem[m_tos] = d;
                if (m_cnt < D) m_cnt++;
                else m_ov = 1;
            end else if (po && m_cnt > 0) begin
                m_tos = (m_tos + D - 1) % D;
                m_cnt--;
            end
        end
    endfunction

    task automatic step(input bit p, input bit po, input logic [31:0] d,
                        input bit ck, input bit rs, input bit st);
        @(negedge clk);
        push = p; pop = po; data = d; checkpoint = ck; restore = rs; stall = st;
        model_step(p, po, d, ck, rs, st);
        sb.push_back(model_out());
    endtask

    task automatic do_push(input logic [31:0] d); step(1, 0, d, 0, 0, 0); endtask
    task automatic do_pop();                     step(0, 1, 0, 0, 0, 0); endtask
    task automatic idle();                       step(0, 0, 0, 0, 0, 0); endtask

    task automatic async_reset();
        exp_t e;
        @(negedge clk);
        push = 0; pop = 0; checkpoint = 0; restore = 0; stall = 0;
        reset = 0;
        model_reset();
        #1;
        e = model_out();
        chk_all(e);
        @(negedge clk);
        reset = 1;
    endtask

    // monitor: outputs are valid every cycle, so each post-edge sample consumes one expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) chk_all(sb.pop_front());
        end
    end

    initial begin
        bit p, po, ck, rs, st;
        model_reset();
        #1;
        chk_all(model_out());
        #12;
        @(negedge clk);
        reset = 1;
        // restore with no snapshot changes nothing
        step(0, 0, 0, 0, 1, 0);
        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        do_pop(); do_pop(); do_pop();
        for (int i = 1; i <= 9; i++) do_push(32'(i * 16));
        idle();
        for (int i = 0; i < 8; i++) do_pop();
        do_pop();
        do_push(32'h30); do_push(32'h40);
        step(1, 1, 32'hA0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 32'h55, 0, 0, 1);
        do_push(32'h77);
        step(1, 0, 32'h66, 0, 1, 1);
        do_pop(); do_pop();
        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        step(0, 0, 0, 1, 0, 0);
        do_pop();
        do_push(32'h999);
        step(0, 0, 0, 0, 1, 0);
        do_pop();
        // checkpoint and restore together: restore wins, snapshot keeps the older state
        do_push(32'h123);
        step(0, 0, 0, 1, 1, 0);
        do_pop(); do_pop();
        step(0, 0, 0, 0, 1, 0);
        do_push(32'hABC);
        async_reset();
        step(0, 0, 0, 0, 1, 0);
        for (int n = 0; n < 2000; n++) begin
            p  = $urandom_range(0, 99) < 50;
            po = $urandom_range(0, 99) < 40;
            ck = $urandom_range(0, 99) < 10;
            rs = $urandom_range(0, 99) < 8;
            st = $urandom_range(0, 99) < 15;
            if (rs && !s_ok) begin p = 0; po = 0; ck = 0; end
            step(p, po, $urandom(), ck, rs, st);
            if (n == 1000) async_reset();
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
